// File: rtl/mcp3202_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mcp3202_scan_ctrl
//  Purpose  : Conversion scheduler for the MCP3202 SPI driver. Paces
//             conversion starts at SAMPLE_DIV clocks, round-robins the two
//             single-ended channels under ch_mask, runs the driver's
//             ready/valid handshake, box-car averages 2^AVG_LOG2 samples per
//             channel and packs raw-sample LSBs into entropy bytes.
//  Ports    : clk, rstn (sync, active-high)     - clock / reset
//             enable, ch_mask                   - scan control
//             adc_start, adc_mode               - to driver (ap_ready, mode)
//             adc_valid, adc_data               - from driver
//             avg0, avg1, avg_valid, avg_ch     - averaged results
//             rnd_byte, rnd_valid               - entropy bytes
//             busy, err_timeout                 - status
//  Revision : 1.0 - initial release
// ============================================================================
module mcp3202_scan_ctrl #(
    parameter int SAMPLE_DIV = 1000,
    parameter int AVG_LOG2   = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic [1:0]  ch_mask,
    output logic        adc_start,
    output logic [1:0]  adc_mode,
    input  logic        adc_valid,
    input  logic [11:0] adc_data,
    output logic [11:0] avg0,
    output logic [11:0] avg1,
    output logic        avg_valid,
    output logic        avg_ch,
    output logic [7:0]  rnd_byte,
    output logic        rnd_valid,
    output logic        busy,
    output logic        err_timeout
);

    localparam int ACC_W  = 12 + AVG_LOG2;
    localparam int CNT_W  = AVG_LOG2 + 1;
    localparam int PACE_W = $clog2(SAMPLE_DIV + 1);

    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(1 << AVG_LOG2);
    localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(SAMPLE_DIV - 1);
    localparam logic [7:0]        TMO_LAST    = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TICK = 3'd1,
        S_START     = 3'd2,
        S_CONV      = 3'd3,
        S_STORE     = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 ch_q, ch_d;         // channel of current / last conversion
    logic [1:0]           mode_q, mode_d;
    logic [PACE_W-1:0]    pace_q, pace_d;
    logic [7:0]           tmo_q, tmo_d;
    logic [11:0]          sample_q, sample_d;
    logic [ACC_W-1:0]     acc_q [2];
    logic [ACC_W-1:0]     acc_d [2];
    logic [CNT_W-1:0]     cnt_q [2];
    logic [CNT_W-1:0]     cnt_d [2];
    logic [7:0]           sr_q, sr_d;
    logic [2:0]           bit_q, bit_d;
    logic                 err_q, err_d;
    // STORE results staged one cycle before they reach the outputs
    logic                 pend_avg_q, pend_avg_d;
    logic                 pend_rnd_q, pend_rnd_d;
    logic                 pend_ch_q, pend_ch_d;
    logic [11:0]          pend_res_q, pend_res_d;

    logic [11:0]          avg0_q, avg1_q;
    logic                 avg_valid_q, avg_ch_q;
    logic [7:0]           rnd_byte_q;
    logic                 rnd_valid_q;

    logic                 w_go;
    logic                 w_next_ch;
    logic [ACC_W-1:0]     w_sum;
    logic [CNT_W-1:0]     w_cnt_inc;

    assign w_go      = enable && (ch_mask != 2'b00);
    // Round robin: first set mask bit after the last serviced channel.
    // ch_q resets to CH1 so the first pick after reset is CH0 when enabled.
    assign w_next_ch = ch_q ? !ch_mask[0] : ch_mask[1];
    assign w_sum     = acc_q[ch_q] + ACC_W'(sample_q);
    assign w_cnt_inc = cnt_q[ch_q] + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        mode_d     = mode_q;
        pace_d     = (pace_q != '0) ? pace_q - PACE_W'(1) : pace_q;
        tmo_d      = tmo_q;
        sample_d   = sample_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        bit_d      = bit_q;
        err_d      = err_q;
        pend_avg_d = 1'b0;
        pend_rnd_d = 1'b0;
        pend_ch_d  = pend_ch_q;
        pend_res_d = pend_res_q;

        case (state_q)
            S_IDLE: begin
                if (w_go) begin
                    state_d = S_WAIT_TICK;
                    ch_d    = w_next_ch;
                end
            end
            S_WAIT_TICK: begin
                if (pace_q == '0) begin
                    state_d = S_START;
                    mode_d  = {1'b1, ch_q};
                    pace_d  = PACE_RELOAD;
                    tmo_d   = 8'd0;
                end
            end
            S_START: begin
                tmo_d = tmo_q + 8'd1;
                if (tmo_q == TMO_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (!adc_valid) begin
                    // valid low means the driver has left STOP/IDLE
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                tmo_d = tmo_q + 8'd1;
                if (tmo_q == TMO_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (adc_valid) begin
                    sample_d = adc_data;
                    state_d  = S_STORE;
                end
            end
            S_STORE: begin
                if (w_cnt_inc == CNT_FULL) begin
                    acc_d[ch_q] = '0;
                    cnt_d[ch_q] = '0;
                    pend_avg_d  = 1'b1;
                    pend_ch_d   = ch_q;
                    pend_res_d  = w_sum[AVG_LOG2 +: 12];
                end else begin
                    acc_d[ch_q] = w_sum;
                    cnt_d[ch_q] = w_cnt_inc;
                end
                // first LSB of a byte ends up in the MSB
                sr_d  = {sr_q[6:0], sample_q[0]};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    pend_rnd_d = 1'b1;
                end
                if (w_go) begin
                    state_d = S_WAIT_TICK;
                    ch_d    = w_next_ch;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q    <= S_IDLE;
            ch_q       <= 1'b1;
            mode_q     <= 2'b10;
            pace_q     <= '0;
            tmo_q      <= '0;
            sample_q   <= '0;
            acc_q      <= '{default: '0};
            cnt_q      <= '{default: '0};
            sr_q       <= '0;
            bit_q      <= '0;
            err_q      <= 1'b0;
            pend_avg_q <= 1'b0;
            pend_rnd_q <= 1'b0;
            pend_ch_q  <= 1'b0;
            pend_res_q <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            mode_q     <= mode_d;
            pace_q     <= pace_d;
            tmo_q      <= tmo_d;
            sample_q   <= sample_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            bit_q      <= bit_d;
            err_q      <= err_d;
            pend_avg_q <= pend_avg_d;
            pend_rnd_q <= pend_rnd_d;
            pend_ch_q  <= pend_ch_d;
            pend_res_q <= pend_res_d;
        end
    end

    // Output stage: publishes staged STORE results as one-cycle pulses.
    // sr_q is stable here because the next STORE is several cycles away.
    always_ff @(posedge clk) begin
        if (rstn) begin
            avg0_q      <= '0;
            avg1_q      <= '0;
            avg_valid_q <= 1'b0;
            avg_ch_q    <= 1'b0;
            rnd_byte_q  <= '0;
            rnd_valid_q <= 1'b0;
        end else begin
            avg_valid_q <= pend_avg_q;
            rnd_valid_q <= pend_rnd_q;
            if (pend_avg_q) begin
                avg_ch_q <= pend_ch_q;
                if (pend_ch_q) begin
                    avg1_q <= pend_res_q;
                end else begin
                    avg0_q <= pend_res_q;
                end
            end
            if (pend_rnd_q) begin
                rnd_byte_q <= sr_q;
            end
        end
    end

    assign adc_start   = (state_q == S_START);
    assign adc_mode    = mode_q;
    assign avg0        = avg0_q;
    assign avg1        = avg1_q;
    assign avg_valid   = avg_valid_q;
    assign avg_ch      = avg_ch_q;
    assign rnd_byte    = rnd_byte_q;
    assign rnd_valid   = rnd_valid_q;
    assign busy        = (state_q != S_IDLE);
    assign err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mcp3202_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mcp3202_scan_ctrl
//  Purpose  : Directed self-checking bench. Instance A (SAMPLE_DIV=16,
//             AVG_LOG2=2, TIMEOUT=20) and instance B (SAMPLE_DIV=12,
//             AVG_LOG2=0) each talk to a small behavioural driver model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mcp3202_scan_ctrl;

    localparam int LAT = 5;   // driver model conversion latency

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- instance A ----------------
    logic        a_en, a_start, a_valid, a_avgv, a_avgch, a_rndv, a_busy, a_err;
    logic [1:0]  a_mask, a_mode;
    logic [11:0] a_data, a_avg0, a_avg1;
    logic [7:0]  a_rnd;
    // ---------------- instance B ----------------
    logic        b_en, b_start, b_valid, b_avgv, b_avgch, b_rndv, b_busy, b_err;
    logic [1:0]  b_mask, b_mode;
    logic [11:0] b_data, b_avg0, b_avg1;
    logic [7:0]  b_rnd;

    mcp3202_scan_ctrl #(.SAMPLE_DIV(16), .AVG_LOG2(2), .TIMEOUT(20)) u_dut_a (
        .clk(clk), .rstn(rst), .enable(a_en), .ch_mask(a_mask),
        .adc_start(a_start), .adc_mode(a_mode), .adc_valid(a_valid), .adc_data(a_data),
        .avg0(a_avg0), .avg1(a_avg1), .avg_valid(a_avgv), .avg_ch(a_avgch),
        .rnd_byte(a_rnd), .rnd_valid(a_rndv), .busy(a_busy), .err_timeout(a_err)
    );

    mcp3202_scan_ctrl #(.SAMPLE_DIV(12), .AVG_LOG2(0), .TIMEOUT(255)) u_dut_b (
        .clk(clk), .rstn(rst), .enable(b_en), .ch_mask(b_mask),
        .adc_start(b_start), .adc_mode(b_mode), .adc_valid(b_valid), .adc_data(b_data),
        .avg0(b_avg0), .avg1(b_avg1), .avg_valid(b_avgv), .avg_ch(b_avgch),
        .rnd_byte(b_rnd), .rnd_valid(b_rndv), .busy(b_busy), .err_timeout(b_err)
    );

    // ---------------- driver model A: per-channel sample tables ----------------
    logic [11:0] a_tbl0 [16];
    logic [11:0] a_tbl1 [16];
    logic [3:0]  a_i0, a_i1;
    logic        a_stall;
    int          a_ph, a_cnt;

    always @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0; a_data <= '0; a_ph <= 0; a_cnt <= 0; a_i0 <= '0; a_i1 <= '0;
        end else begin
            case (a_ph)
                0: if (a_start) begin a_ph <= 1; a_cnt <= LAT; end
                1: if (!a_stall) begin
                       if (a_cnt == 1) begin
                           a_valid <= 1'b1;
                           a_ph    <= 2;
                           if (a_mode[0]) begin a_data <= a_tbl1[a_i1]; a_i1 <= a_i1 + 4'd1; end
                           else           begin a_data <= a_tbl0[a_i0]; a_i0 <= a_i0 + 4'd1; end
                       end else begin
                           a_cnt <= a_cnt - 1;
                       end
                   end
                default: begin a_valid <= 1'b0; a_ph <= 0; end
            endcase
        end
    end

    // ---------------- driver model B: constant word, optional STOP hold ----------------
    logic [11:0] b_word;
    logic        b_hold;   // 1: valid stays high (STOP) until the next start
    int          b_ph, b_cnt;

    always @(posedge clk) begin
        if (rst) begin
            b_valid <= 1'b0; b_data <= '0; b_ph <= 0; b_cnt <= 0;
        end else begin
            case (b_ph)
                0: if (b_start) begin b_ph <= 1; b_cnt <= LAT; end
                1: if (b_cnt == 1) begin b_valid <= 1'b1; b_data <= b_word; b_ph <= 2; end
                   else b_cnt <= b_cnt - 1;
                default: begin
                    if (!b_hold) begin b_valid <= 1'b0; b_ph <= 0; end
                    else if (b_start) begin b_valid <= 1'b0; b_ph <= 1; b_cnt <= LAT; end
                end
            endcase
        end
    end

    // ---------------- monitors ----------------
    int   ecnt = 0;          // index of the latest rising edge
    int   b_vedge = 0;
    logic b_valid_prev = 1'b0;
    always @(posedge clk) begin
        ecnt = ecnt + 1;
        if (b_valid && !b_valid_prev) b_vedge = ecnt;
        b_valid_prev = b_valid;
    end

    int   b_navg = 0, b_av_lat = -1, b_nstart = 0, b_gap = -1, b_last_start = 0, b_len = 0;
    int   b_len_log [16];
    logic b_start_d = 1'b0;
    int   a_navg = 0, a_nrnd = 0, a_nstart = 0, a_avg_edge = -1, a_rnd_edge = -2;
    logic a_ch_log [8];
    logic [1:0] a_mode_log [16];
    logic a_start_d = 1'b0;

    always @(negedge clk) begin
        if (b_avgv) begin b_navg = b_navg + 1; b_av_lat = ecnt - b_vedge; end
        if (b_start && !b_start_d) begin
            if (b_nstart > 0) b_gap = ecnt - b_last_start;
            b_last_start = ecnt;
            b_nstart     = b_nstart + 1;
            b_len        = 0;
        end
        if (b_start) b_len = b_len + 1;
        if (!b_start && b_start_d && b_nstart <= 16) b_len_log[b_nstart-1] = b_len;
        b_start_d = b_start;

        if (a_avgv) begin
            if (a_navg < 8) a_ch_log[a_navg] = a_avgch;
            a_navg     = a_navg + 1;
            a_avg_edge = ecnt;
        end
        if (a_rndv) begin a_nrnd = a_nrnd + 1; a_rnd_edge = ecnt; end
        if (a_start && !a_start_d) begin
            if (a_nstart < 16) a_mode_log[a_nstart] = a_mode;
            a_nstart = a_nstart + 1;
        end
        a_start_d = a_start;
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        a_en = 1'b0; b_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic a_wait_idle(input string tag);
        for (int k = 0; k < 200 && a_busy; k++) @(negedge clk);
        check_eq(tag, 32'(a_busy), 32'd0);
    endtask

    task automatic b_wait_idle(input string tag);
        for (int k = 0; k < 200 && b_busy; k++) @(negedge clk);
        check_eq(tag, 32'(b_busy), 32'd0);
    endtask

    int base_avg, base_rnd, base_start;

    initial begin
        a_mask = 2'b00; b_mask = 2'b00; a_stall = 1'b0; b_hold = 1'b0; b_word = 12'h000;
        for (int i = 0; i < 16; i++) begin a_tbl0[i] = '0; a_tbl1[i] = '0; b_len_log[i] = 0; end
        apply_reset();

        // ---- reset state, both instances ----
        check_eq("rst_a_outputs", {a_start, a_mode, a_avg0, a_avg1, a_avgv, a_avgch},
                 {1'b0, 2'b10, 12'h0, 12'h0, 1'b0, 1'b0});
        check_eq("rst_a_status", {a_rnd, a_rndv, a_busy, a_err}, 11'h0);
        check_eq("rst_b_outputs", {b_start, b_mode, b_avg0, b_avg1, b_avgv, b_avgch, b_rnd, b_rndv, b_busy, b_err},
                 {1'b0, 2'b10, 24'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0});

        // ---- B: CH0 only, no averaging, driver holding valid in STOP ----
        b_word = 12'hA5C; b_hold = 1'b1; b_mask = 2'b01; b_en = 1'b1;
        for (int k = 0; k < 300 && b_navg < 3; k++) @(negedge clk);
        check_eq("b_three_results", 32'(b_navg), 32'd3);
        check_eq("b_avg0", 32'(b_avg0), 32'hA5C);
        check_eq("b_avg_ch", 32'(b_avgch), 32'd0);
        check_eq("b_mode_ch0", 32'(b_mode), 32'b10);
        check_eq("b_start_spacing", 32'(b_gap), 32'd12);
        check_eq("b_pulse_per_conv", 32'(b_nstart), 32'(b_navg));
        check_eq("b_start_len_from_idle", 32'(b_len_log[0]), 32'd1);
        check_eq("b_start_len_from_stop", 32'(b_len_log[1]), 32'd2);
        check_eq("b_avg_valid_latency", 32'(b_av_lat), 32'd2);
        b_en = 1'b0;
        b_wait_idle("b_idle_after_scan");

        // ---- A: both channels, 4-sample average ----
        apply_reset();
        for (int i = 0; i < 16; i++) begin a_tbl0[i] = 12'd100; a_tbl1[i] = 12'd3000; end
        a_mask = 2'b11; a_en = 1'b1;
        for (int k = 0; k < 400 && a_navg < 2; k++) @(negedge clk);
        a_en = 1'b0;
        a_wait_idle("a_idle_after_dual");
        check_eq("a_dual_pulses", 32'(a_navg), 32'd2);
        check_eq("a_dual_avg0", 32'(a_avg0), 32'd100);
        check_eq("a_dual_avg1", 32'(a_avg1), 32'd3000);
        check_eq("a_dual_ch_first", 32'(a_ch_log[0]), 32'd0);
        check_eq("a_dual_ch_second", 32'(a_ch_log[1]), 32'd1);
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("a_mode_alt%0d", i), 32'(a_mode_log[i]), (i % 2 == 0) ? 32'b10 : 32'b11);

        // ---- A: accumulator headroom, 4095+4095+0+1 ----
        apply_reset();
        for (int i = 0; i < 16; i++) begin a_tbl0[i] = '0; a_tbl1[i] = '0; end
        a_tbl0[0] = 12'd4095; a_tbl0[1] = 12'd4095; a_tbl0[2] = 12'd0; a_tbl0[3] = 12'd1;
        base_avg = a_navg;
        a_mask = 2'b01; a_en = 1'b1;
        for (int k = 0; k < 200 && a_navg < base_avg + 1; k++) @(negedge clk);
        a_en = 1'b0;
        a_wait_idle("a_idle_after_ovf");
        check_eq("a_ovf_avg0", 32'(a_avg0), 32'd2047);
        check_eq("a_ovf_avg1_untouched", 32'(a_avg1), 32'd0);

        // ---- A: entropy byte from LSBs 1,0,1,1,0,0,1,0 ----
        apply_reset();
        a_tbl0[0] = 12'h001; a_tbl0[1] = 12'h002; a_tbl0[2] = 12'h003; a_tbl0[3] = 12'h005;
        a_tbl0[4] = 12'h010; a_tbl0[5] = 12'h020; a_tbl0[6] = 12'h7FF; a_tbl0[7] = 12'h800;
        base_rnd = a_nrnd;
        a_mask = 2'b01; a_en = 1'b1;
        for (int k = 0; k < 400 && a_nrnd < base_rnd + 1; k++) @(negedge clk);
        a_en = 1'b0;
        a_wait_idle("a_idle_after_rnd");
        check_eq("a_rnd_byte", 32'(a_rnd), 32'hB2);
        check_eq("a_rnd_single_pulse", 32'(a_nrnd - base_rnd), 32'd1);
        check_eq("a_rnd_avg_same_cycle", 32'(a_rnd_edge), 32'(a_avg_edge));
        check_eq("a_rnd_avg0", 32'(a_avg0), 32'h40B);   // (0x10+0x20+0x7FF+0x800)>>2

        // ---- A: stalled driver, timeout after 20 cycles in START/CONV ----
        apply_reset();
        a_stall = 1'b1; base_avg = a_navg;
        a_mask = 2'b01; a_en = 1'b1;
        for (int k = 0; k < 50 && !a_start; k++) @(negedge clk);
        check_eq("a_tmo_started", 32'(a_start), 32'd1);
        repeat (19) @(negedge clk);
        check_eq("a_tmo_busy_cycle19", {a_busy, a_err}, 2'b10);
        @(negedge clk);
        check_eq("a_tmo_abort", {a_busy, a_start, a_err}, 3'b001);
        a_en = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("a_tmo_err_sticky", {a_busy, a_err}, 2'b01);
        check_eq("a_tmo_no_avg", 32'(a_navg - base_avg), 32'd0);
        apply_reset();
        a_stall = 1'b0;
        check_eq("a_tmo_err_cleared", 32'(a_err), 32'd0);

        // ---- B: enable dropped during CONV ----
        b_hold = 1'b0;
        apply_reset();
        b_word = 12'h123; b_mask = 2'b01; b_en = 1'b1;
        base_avg = b_navg; base_start = b_nstart;
        for (int k = 0; k < 50 && !b_start; k++) @(negedge clk);
        @(negedge clk);
        check_eq("b_drop_in_conv", {b_busy, b_start}, 2'b10);
        b_en = 1'b0;
        for (int k = 0; k < 50 && b_navg < base_avg + 1; k++) @(negedge clk);
        check_eq("b_drop_result", 32'(b_avg0), 32'h123);
        b_wait_idle("b_drop_idle");
        repeat (30) @(negedge clk);
        check_eq("b_drop_no_restart", 32'(b_nstart - base_start), 32'd1);
        check_eq("b_drop_quiet", {b_busy, b_start}, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
